// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command to APB4 initiator; ACCESS timeout enabled by APB_MASTER_TIMEOUT_EN
module apb_cmd_master #(
  parameter int AW = 12,
  parameter int TO_CYCLES = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [31:0]   cmd_wdata,
  input  logic [3:0]    cmd_strb,
  input  logic [2:0]    cmd_prot,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [31:0]   PWDATA,
  output logic [3:0]    PSTRB,
  output logic [2:0]    PPROT,
  output logic          APBACTIVE,
  input  logic [31:0]   PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic rdy_q, rdy_d, wr_q, wr_d, err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] strb_q, strb_d;
  logic [2:0] prot_q, prot_d;
  logic accept, done, expire;
  if (TO_CYCLES < 2 || TO_CYCLES > 65535) begin : g_bad_to_cycles
    $error("TO_CYCLES must be in 2..65535");
  end
  assign accept = rdy_q && cmd_valid;
  assign done = (state_q == ACCESS) && PREADY;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = (PREADY || expire) ? RESP : ACCESS;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    rdy_d = state_d == IDLE;
    addr_d = accept ? cmd_addr : addr_q;
    wr_d = accept ? cmd_write : wr_q;
    prot_d = accept ? cmd_prot : prot_q;
    wdata_d = accept ? (cmd_write ? cmd_wdata : 32'd0) : wdata_q;
    strb_d = accept ? (cmd_write ? cmd_strb : 4'd0) : strb_q;
    rdata_d = done ? (wr_q ? 32'd0 : PRDATA) : expire ? 32'd0 : rdata_q;
    err_d = done ? PSLVERR : expire ? 1'b1 : err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdy_q <= 1'b0;
      addr_q <= '0;
      wr_q <= 1'b0;
      prot_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q <= rdy_d;
      addr_q <= addr_d;
      wr_q <= wr_d;
      prot_q <= prot_d;
      wdata_q <= wdata_d;
      strb_q <= strb_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic to_q, to_d;
  // cnt_q counts completed wait cycles, so it reads TO_CYCLES-1 in the TO_CYCLES-th ACCESS cycle
  assign expire = (state_q == ACCESS) && !PREADY && (cnt_q == 16'(TO_CYCLES - 1));
  always_comb begin
    cnt_d = (state_q == SETUP) ? 16'd0 : (state_q == ACCESS && !PREADY) ? cnt_q + 16'd1 : cnt_q;
    to_d = done ? 1'b0 : expire ? 1'b1 : to_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q <= to_d;
    end
  end
  assign rsp_timeout = to_q;
`else
  assign expire = 1'b0;
  assign rsp_timeout = 1'b0;
`endif
  assign cmd_ready = rdy_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
  assign PSEL = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE = state_q == ACCESS;
  assign APBACTIVE = (state_q == SETUP) || (state_q == ACCESS);
  assign PWRITE = wr_q;
  assign PADDR = addr_q;
  assign PWDATA = wdata_q;
  assign PSTRB = strb_q;
  assign PPROT = prot_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed commands with a scoreboard monitor on APB and response ports
module tb_apb_cmd_master;
  localparam int AW = 12;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0] cmd_strb = '0;
  logic [2:0] cmd_prot = '0;
  logic cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic PSEL, PENABLE, PWRITE, APBACTIVE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic [3:0] PSTRB;
  logic [2:0] PPROT;
  int wait_n = 0, acc_cnt = 0, hold_n = 0, cyc = 0, acc_cyc = -1, hs_cyc = -1;
  int n_chk = 0, n_fail = 0;
  logic [31:0] rd_val = '0;
  logic err_val = 1'b0;
  bit in_rsp = 0, post_hs = 0;
  typedef struct {
    logic w; logic [AW-1:0] a; logic [31:0] wd; logic [3:0] s; logic [2:0] p;
    bit rsp; logic [31:0] rd; logic err; logic to; int lat;
  } exp_t;
  exp_t cmd_q[$], rsp_q[$];
  exp_t cur, rcur;

  apb_cmd_master #(.AW(AW), .TO_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .APBACTIVE(APBACTIVE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // slave: ready on the (wait_n+1)-th ACCESS cycle, garbage read data otherwise
  always @(posedge clk) acc_cnt <= (PSEL && PENABLE) ? acc_cnt + 1 : 0;
  assign PREADY = PSEL && PENABLE && (acc_cnt == wait_n);
  assign PRDATA = PREADY ? rd_val : 32'hDEAD_BEEF;
  assign PSLVERR = PREADY && err_val;
  always @(posedge clk) begin
    #1;
    if (rsp_valid && hold_n > 0) begin
      rsp_ready = 1'b0;
      hold_n--;
    end else rsp_ready = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_rsp = 0;
      post_hs = 0;
    end else begin
      if (post_hs) begin
        chk("cmd_ready_after_hs", cmd_ready, 1);
        post_hs = 0;
      end
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc;
        if (cmd_q.size() == 0) chk("unexpected_accept", 1, 0);
        else begin
          cur = cmd_q.pop_front();
          if (cur.rsp) rsp_q.push_back(cur);
        end
      end
      if (PSEL) begin
        if (!PENABLE) chk("setup_cycle", cyc - acc_cyc, 1);
        else if (acc_cnt == 0) chk("access_cycle", cyc - acc_cyc, 2);
        chk("paddr", PADDR, cur.a);
        chk("pwrite", PWRITE, cur.w);
        chk("pwdata", PWDATA, cur.wd);
        chk("pstrb", PSTRB, cur.s);
        chk("pprot", PPROT, cur.p);
        chk("apb_busy", {APBACTIVE, cmd_ready, rsp_valid}, 3'b100);
      end else chk("apb_quiet", {APBACTIVE, PENABLE}, 0);
      if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1;
          if (rsp_q.size() == 0) chk("unexpected_rsp", 1, 0);
          else begin
            rcur = rsp_q.pop_front();
            chk("rsp_latency", cyc - acc_cyc, rcur.lat);
          end
        end
        chk("rsp_rdata", rsp_rdata, rcur.rd);
        chk("rsp_err", rsp_err, rcur.err);
        chk("rsp_timeout", rsp_timeout, rcur.to);
        chk("rsp_cmd_ready", cmd_ready, 0);
        if (rsp_ready) begin
          in_rsp = 0;
          hs_cyc = cyc;
          post_hs = 1;
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input logic [2:0] p, input bit rsp,
                       input logic [31:0] rd, input logic e, input logic to, input int lat);
    exp_t x;
    x.w = w; x.a = a; x.wd = w ? wd : 32'd0; x.s = w ? s : 4'd0; x.p = p;
    x.rsp = rsp; x.rd = rd; x.err = e; x.to = to; x.lat = lat;
    cmd_q.push_back(x);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_strb = s; cmd_prot = p;
  endtask

  task automatic wait_acc(output int c);
    bit ok = 0;
    c = -1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready && cmd_valid) begin
        ok = 1;
        c = cyc;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic drop_valid();
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready && !in_rsp && rsp_q.size() == 0 && cmd_q.size() == 0;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic one(input logic w, input logic [AW-1:0] a, input logic [31:0] wd,
                     input logic [3:0] s, input logic [2:0] p,
                     input logic [31:0] rd, input logic e, input logic to, input int lat);
    int c;
    issue(w, a, wd, s, p, 1, rd, e, to, lat);
    wait_acc(c);
    drop_valid();
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE,
        PWRITE, PADDR, PWDATA, PSTRB, PPROT, APBACTIVE} == 0, 1);
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1);
    @(posedge clk);
    #1;
    wait_n = 0;
    one(1, 12'h018, 32'h0000_0ABC, 4'hF, 3'd0, 32'd0, 0, 0, 3);
    wait_n = 3; rd_val = 32'h1234_5678;
    one(0, 12'h02C, 32'hFFFF_FFFF, 4'hF, 3'd2, 32'h1234_5678, 0, 0, 6);
    wait_n = 1; rd_val = 32'hCAFE_0001; err_val = 1'b1; hold_n = 5;
    one(0, 12'h040, 32'd0, 4'h0, 3'd1, 32'hCAFE_0001, 1, 0, 4);
    err_val = 1'b0;
    wait_n = 2;
    one(1, 12'hFFC, 32'hA5A5_5A5A, 4'h5, 3'd7, 32'd0, 0, 0, 5);
    wait_n = 0; err_val = 1'b1;
    one(1, 12'h010, 32'h0000_0001, 4'h1, 3'd0, 32'd0, 1, 0, 3);
    err_val = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_n = 1000; rd_val = 32'h5555_AAAA;
    one(0, 12'h100, 32'd0, 4'h0, 3'd0, 32'd0, 1, 1, 6);
    wait_n = 3;
    one(0, 12'h104, 32'd0, 4'h0, 3'd0, 32'h5555_AAAA, 0, 0, 6);
`endif
    // reset lands in the second ACCESS cycle; no response may follow
    wait_n = 10;
    issue(0, 12'h080, 32'd0, 4'h0, 3'd3, 0, 32'd0, 0, 0, 0);
    wait_acc(c1);
    drop_valid();
    c2 = 0;
    for (int i = 0; i < 20 && c2 == 0; i++) begin
      @(negedge clk);
      if (PSEL && PENABLE && acc_cnt == 1) c2 = 1;
    end
    chk("reached_access2", c2, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE,
        PWRITE, PADDR, PWDATA, PSTRB, PPROT, APBACTIVE} == 0, 1);
    wait_idle();
    wait_n = 0;
    one(1, 12'h084, 32'h0BAD_F00D, 4'hC, 3'd0, 32'd0, 0, 0, 3);
    // back-to-back: valid stays high, second accept right after first handshake
    issue(1, 12'h200, 32'h1111_1111, 4'hF, 3'd0, 1, 32'd0, 0, 0, 3);
    wait_acc(c1);
    @(posedge clk);
    #1 issue(1, 12'h204, 32'h2222_2222, 4'h3, 3'd4, 1, 32'd0, 0, 0, 3);
    wait_acc(c2);
    chk("b2b_second_accept", c2, hs_cyc + 1);
    chk("b2b_spacing", c2 - c1, 4);
    drop_valid();
    wait_idle();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
